// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the UART instruction loader: parity modes, RX FSM
// states and the default baud divisor.
package cpu_loader_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int CLKS_PER_BIT_115200 = 868;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // True when the received parity bit matches the configured mode.
  function automatic logic parity_ok(input logic [7:0] data, input logic par_bit,
                                     input int mode);
    case (mode)
      PARITY_EVEN: return ~^{data, par_bit};
      PARITY_ODD:  return ^{data, par_bit};
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/uart_word_loader_if.sv
// Instruction-memory write port and load status, driven by the loader (master)
// and observed by the CPU top level (slave).
interface uart_word_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              o_load_done;
  logic [ADDR_W-1:0] o_max_addr;
  logic [ADDR_W:0]   o_word_count;
  logic              o_frame_err;
  logic              o_parity_err;
  logic              o_overflow;

  modport master (
    output o_mem_we, o_mem_addr, o_mem_wdata, o_load_done, o_max_addr,
           o_word_count, o_frame_err, o_parity_err, o_overflow
  );

  modport slave (
    input o_mem_we, o_mem_addr, o_mem_wdata, o_load_done, o_max_addr,
          o_word_count, o_frame_err, o_parity_err, o_overflow
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling FSM, parity and stop checks.
// Result pulses are combinational in the stop-bit sample cycle.
module uart_rx_core
  import cpu_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int PARITY       = PARITY_NONE
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_rx,
  output logic       o_byte_valid,
  output logic [7:0] o_byte,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_line_idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1, r_sync2, r_rx_d;
  rx_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_par, w_par_nxt;
  logic             w_rx, w_fall;

  // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values;
  // blocking (=) is reserved for always_comb.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  assign w_rx        = r_sync2;
  assign w_fall      = r_rx_d & ~r_sync2;
  assign o_byte      = r_shift;
  assign o_line_idle = (r_state == RX_IDLE) && w_rx;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_par     <= w_par_nxt;
    end
  end

  // r_cnt counts cycles since the falling edge (START) or since the last sample.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_par_nxt     = r_par;
    o_byte_valid  = 1'b0;
    o_frame_err   = 1'b0;
    o_parity_err  = 1'b0;

    unique case (r_state)
      RX_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = RX_START;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      RX_START: begin
        if (r_cnt == HALF_BIT) begin
          w_cnt_nxt     = CNT_ONE;
          w_bit_idx_nxt = '0;
          w_state_nxt   = w_rx ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL_BIT) begin
          w_cnt_nxt     = CNT_ONE;
          w_shift_nxt   = {w_rx, r_shift[7:1]};
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7)
            w_state_nxt = (PARITY == PARITY_NONE) ? RX_STOP : RX_PARITY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_PARITY: begin
        if (r_cnt == FULL_BIT) begin
          w_cnt_nxt   = CNT_ONE;
          w_par_nxt   = w_rx;
          w_state_nxt = RX_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == FULL_BIT) begin
          // Leaving at mid-stop lets the next start edge be caught in the second half.
          w_cnt_nxt   = '0;
          w_state_nxt = RX_IDLE;
          if (!w_rx)
            o_frame_err = 1'b1;
          else if (!parity_ok(r_shift, r_par, PARITY))
            o_parity_err = 1'b1;
          else
            o_byte_valid = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_word_loader.sv
// Assembles UART bytes MSB-first into words and writes them to sequential
// instruction-memory addresses; tracks idle timeout, progress and sticky errors.
module uart_word_loader
  import cpu_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES   = 2,
  parameter int ADDR_W       = 8,
  parameter int START_ADDR   = 1,
  parameter int PARITY       = PARITY_NONE,
  parameter int IDLE_BITS    = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  input  logic i_enable,
  input  logic i_clear,
  uart_word_loader_if.master o_bus
);

  localparam int DATA_W  = 8 * WORD_BYTES;
  localparam int BCNT_W  = $clog2(WORD_BYTES + 1);
  localparam int TIMEOUT = IDLE_BITS * CLKS_PER_BIT;
  localparam int TMR_W   = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [BCNT_W-1:0] LAST_BYTE  = BCNT_W'(WORD_BYTES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST   = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  TMR_FULL   = TMR_W'(TIMEOUT);

  logic       w_byte_valid, w_frame_err_p, w_parity_err_p, w_line_idle;
  logic [7:0] w_byte;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .PARITY      (PARITY)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clear     (i_clear),
    .i_rx        (i_rx),
    .o_byte_valid(w_byte_valid),
    .o_byte      (w_byte),
    .o_frame_err (w_frame_err_p),
    .o_parity_err(w_parity_err_p),
    .o_line_idle (w_line_idle)
  );

  logic [DATA_W-1:0] r_word;
  logic [BCNT_W-1:0] r_byte_cnt;
  logic [ADDR_W-1:0] r_next_addr;
  logic              r_exhausted;
  logic [TMR_W-1:0]  r_idle_cnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_load_done;
  logic [ADDR_W-1:0] r_max_addr;
  logic [ADDR_W:0]   r_word_count;
  logic              r_frame_err, r_parity_err, r_overflow;

  logic [DATA_W-1:0] w_word_nxt;
  logic              w_word_done, w_accept, w_write, w_drop, w_timeout;

  // Truncating the concatenation keeps the oldest byte at the top once the word fills.
  assign w_word_nxt  = DATA_W'({r_word, w_byte});
  assign w_word_done = w_byte_valid && i_enable && (r_byte_cnt == LAST_BYTE);
  assign w_accept    = w_word_done && !r_load_done;
  assign w_write     = w_accept && !r_exhausted;
  assign w_drop      = w_accept && r_exhausted;
  assign w_timeout   = w_line_idle && (r_idle_cnt == TMR_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_word       <= '0;
      r_byte_cnt   <= '0;
      r_next_addr  <= FIRST_ADDR;
      r_exhausted  <= 1'b0;
      r_idle_cnt   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_load_done  <= 1'b0;
      r_max_addr   <= FIRST_ADDR;
      r_word_count <= '0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_mem_we <= w_write;
      if (w_write) begin
        r_mem_addr   <= r_next_addr;
        r_mem_wdata  <= w_word_nxt;
        r_max_addr   <= r_next_addr;
        r_word_count <= r_word_count + 1'b1;
        // The top address is written once, then the space is marked exhausted.
        if (r_next_addr == LAST_ADDR)
          r_exhausted <= 1'b1;
        else
          r_next_addr <= r_next_addr + 1'b1;
      end
      if (w_drop)         r_overflow   <= 1'b1;
      if (w_frame_err_p)  r_frame_err  <= 1'b1;
      if (w_parity_err_p) r_parity_err <= 1'b1;

      if (!w_line_idle)
        r_idle_cnt <= '0;
      else if (r_idle_cnt != TMR_FULL)
        r_idle_cnt <= r_idle_cnt + 1'b1;
      if (w_timeout && (r_word_count != '0))
        r_load_done <= 1'b1;

      if (w_timeout || w_frame_err_p || w_parity_err_p || !i_enable) begin
        r_byte_cnt <= '0;
      end else if (w_byte_valid) begin
        r_word     <= w_word_nxt;
        r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + 1'b1;
      end
    end
  end

  assign o_bus.o_mem_we     = r_mem_we;
  assign o_bus.o_mem_addr   = r_mem_addr;
  assign o_bus.o_mem_wdata  = r_mem_wdata;
  assign o_bus.o_load_done  = r_load_done;
  assign o_bus.o_max_addr   = r_max_addr;
  assign o_bus.o_word_count = r_word_count;
  assign o_bus.o_frame_err  = r_frame_err;
  assign o_bus.o_parity_err = r_parity_err;
  assign o_bus.o_overflow   = r_overflow;

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed + randomized bench: loader A (defaults, 8 clocks/bit) and loader B
// (odd parity, 3-bit addresses) checked against a byte-level reference model.
module tb_uart_word_loader;
  import cpu_loader_pkg::*;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, en_a, en_b, clr_a, clr_b;
  logic [1:0] rx;

  always #5 clk = ~clk;

  uart_word_loader_if #(.ADDR_W(8), .DATA_W(16)) bus_a ();
  uart_word_loader_if #(.ADDR_W(3), .DATA_W(16)) bus_b ();

  uart_word_loader #(.CLKS_PER_BIT(CPB)) dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_rx(rx[0]), .i_enable(en_a), .i_clear(clr_a),
    .o_bus(bus_a)
  );

  uart_word_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(3), .PARITY(PARITY_ODD)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_rx(rx[1]), .i_enable(en_b), .i_clear(clr_b),
    .o_bus(bus_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Observed writes, packed as (addr << 16) | data.
  logic [31:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  logic        prev_we_a = 1'b0, prev_we_b = 1'b0;
  int          n_long_we = 0;

  always @(negedge clk) begin
    if (bus_a.o_mem_we) begin
      got_a.push_back(32'({bus_a.o_mem_addr, bus_a.o_mem_wdata}));
      if (prev_we_a) n_long_we++;
    end
    if (bus_b.o_mem_we) begin
      got_b.push_back(32'({bus_b.o_mem_addr, bus_b.o_mem_wdata}));
      if (prev_we_b) n_long_we++;
    end
    prev_we_a <= bus_a.o_mem_we;
    prev_we_b <= bus_b.o_mem_we;
  end

  // Reference model: one entry per loader.
  int          m_nb[2], m_next[2], m_max[2], m_cnt[2];
  logic [15:0] m_word[2];
  bit          m_exh[2], m_done[2], m_ferr[2], m_perr[2], m_ovf[2];
  int          m_amax[2] = '{255, 7};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic m_reset(input int d);
    m_nb[d] = 0; m_word[d] = '0; m_next[d] = 1; m_max[d] = 1; m_cnt[d] = 0;
    m_exh[d] = 0; m_done[d] = 0; m_ferr[d] = 0; m_perr[d] = 0; m_ovf[d] = 0;
  endtask

  task automatic m_byte(input int d, input logic [7:0] b, input bit stop_ok, input bit par_ok);
    bit en;
    en = (d == 0) ? en_a : en_b;
    if (!stop_ok) begin
      m_ferr[d] = 1; m_nb[d] = 0;
    end else if (!par_ok) begin
      m_perr[d] = 1; m_nb[d] = 0;
    end else if (!en) begin
      m_nb[d] = 0;
    end else begin
      m_word[d] = {m_word[d][7:0], b};
      m_nb[d]++;
      if (m_nb[d] == 2) begin
        m_nb[d] = 0;
        if (!m_done[d]) begin
          if (m_exh[d]) m_ovf[d] = 1;
          else begin
            if (d == 0) exp_a.push_back((32'(m_next[d]) << 16) | 32'(m_word[d]));
            else        exp_b.push_back((32'(m_next[d]) << 16) | 32'(m_word[d]));
            m_max[d] = m_next[d];
            m_cnt[d]++;
            if (m_next[d] == m_amax[d]) m_exh[d] = 1;
            else m_next[d]++;
          end
        end
      end
    end
  endtask

  task automatic m_timeout(input int d);
    m_nb[d] = 0;
    if (m_cnt[d] > 0) m_done[d] = 1;
  endtask

  // Called at a falling clock edge; holds the line for n cycles.
  task automatic drive(input int d, input logic v, input int n);
    rx[d] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int d, input logic [7:0] b, input bit stop_ok, input bit par_good);
    drive(d, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(d, b[i], CPB);
    if (d == 1) drive(d, par_good ? ~^b : ^b, CPB);
    drive(d, stop_ok, CPB);
    if (!stop_ok) drive(d, 1'b1, 2 * CPB);
    m_byte(d, b, stop_ok, (d == 1) ? par_good : 1'b1);
  endtask

  task automatic send_word(input int d);
    send_frame(d, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
    send_frame(d, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
  endtask

  task automatic pulse_clear(input int d);
    if (d == 0) clr_a = 1'b1; else clr_b = 1'b1;
    @(negedge clk);
    if (d == 0) clr_a = 1'b0; else clr_b = 1'b0;
    m_reset(d);
    @(negedge clk);
  endtask

  task automatic check_state(input int d, input string tag);
    if (d == 0) begin
      check({tag, ".nwr"}, got_a.size(), exp_a.size());
      for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
        check($sformatf("%s.wr%0d", tag, i), got_a[i], exp_a[i]);
      got_a.delete(); exp_a.delete();
      check({tag, ".max"},  bus_a.o_max_addr,   m_max[0]);
      check({tag, ".cnt"},  bus_a.o_word_count, m_cnt[0]);
      check({tag, ".done"}, bus_a.o_load_done,  m_done[0]);
      check({tag, ".ferr"}, bus_a.o_frame_err,  m_ferr[0]);
      check({tag, ".perr"}, bus_a.o_parity_err, m_perr[0]);
      check({tag, ".ovf"},  bus_a.o_overflow,   m_ovf[0]);
    end else begin
      check({tag, ".nwr"}, got_b.size(), exp_b.size());
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
        check($sformatf("%s.wr%0d", tag, i), got_b[i], exp_b[i]);
      got_b.delete(); exp_b.delete();
      check({tag, ".max"},  bus_b.o_max_addr,   m_max[1]);
      check({tag, ".cnt"},  bus_b.o_word_count, m_cnt[1]);
      check({tag, ".done"}, bus_b.o_load_done,  m_done[1]);
      check({tag, ".ferr"}, bus_b.o_frame_err,  m_ferr[1]);
      check({tag, ".perr"}, bus_b.o_parity_err, m_perr[1]);
      check({tag, ".ovf"},  bus_b.o_overflow,   m_ovf[1]);
    end
  endtask

  initial begin
    logic [7:0] b0, b1;
    rx = 2'b11; rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;
    m_reset(0); m_reset(1);
    repeat (4) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst.we_a",    bus_a.o_mem_we,    0);
    check("rst.addr_a",  bus_a.o_mem_addr,  0);
    check("rst.wdata_a", bus_a.o_mem_wdata, 0);
    check("rst.we_b",    bus_b.o_mem_we,    0);
    check_state(0, "rst_a");
    check_state(1, "rst_b");

    // 0x41, 0x00 -> one write of 0x4100 at address 1
    send_frame(0, 8'h41, 1'b1, 1'b1);
    send_frame(0, 8'h00, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("t1.addr",  bus_a.o_mem_addr,  1);
    check("t1.wdata", bus_a.o_mem_wdata, 16'h4100);
    check_state(0, "t1");

    // 15 random words, then idle timeout sets load_done
    pulse_clear(0);
    for (int w = 0; w < 15; w++) send_word(0);
    repeat (140) @(negedge clk);
    check("t2.done_early", bus_a.o_load_done, 0);
    repeat (30) @(negedge clk);
    check("t2.done", bus_a.o_load_done, 1);
    check("t2.max",  bus_a.o_max_addr,  15);
    m_timeout(0);
    check_state(0, "t2");

    // Framing error then a clean word
    pulse_clear(0);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    send_frame(0, 8'h81, 1'b1, 1'b1);
    send_frame(0, 8'h80, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("t3.wdata", bus_a.o_mem_wdata, 16'h8180);
    check("t3.ferr",  bus_a.o_frame_err, 1);
    check_state(0, "t3");

    // Disabled: bytes decoded but nothing assembled
    pulse_clear(0);
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(0, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
    en_a = 1'b1;
    send_word(0);
    repeat (4) @(negedge clk);
    check_state(0, "t4");

    // Short low glitch is not a byte
    pulse_clear(0);
    drive(0, 1'b0, 2);
    drive(0, 1'b1, 20);
    send_word(0);
    repeat (4) @(negedge clk);
    check_state(0, "t5");

    // Reset in the middle of a word's second byte
    pulse_clear(0);
    send_frame(0, 8'($urandom_range(0, 255)), 1'b1, 1'b1);
    drive(0, 1'b0, CPB);
    drive(0, 1'b1, CPB);
    drive(0, 1'b0, CPB / 2);
    rst_a = 1'b1; rx[0] = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    m_reset(0);
    check("t6.we_rst", bus_a.o_mem_we, 0);
    drive(0, 1'b1, 30);
    check("t6.nwr_rst", got_a.size(), 0);
    send_word(0);
    repeat (4) @(negedge clk);
    check("t6.addr", bus_a.o_mem_addr, 1);
    check_state(0, "t6");

    // Load done blocks writes; clear restores everything
    repeat (170) @(negedge clk);
    m_timeout(0);
    check("t7.done", bus_a.o_load_done, 1);
    send_word(0);
    repeat (4) @(negedge clk);
    check_state(0, "t7.blocked");
    pulse_clear(0);
    check_state(0, "t7.clr");
    send_word(0);
    repeat (4) @(negedge clk);
    check("t7.addr", bus_a.o_mem_addr, 1);
    check_state(0, "t7.after");

    // Odd parity: wrong parity bit drops the byte, correct resend writes
    b0 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    send_frame(1, b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("t8.perr", bus_b.o_parity_err, 1);
    check_state(1, "t8.bad");
    send_frame(1, b0, 1'b1, 1'b1);
    send_frame(1, b1, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("t8.wr", 32'({bus_b.o_mem_addr, bus_b.o_mem_wdata}), {13'd0, 3'd1, b0, b1});
    check_state(1, "t8");

    // Address space exhaustion with 3-bit addresses
    pulse_clear(1);
    for (int w = 0; w < 8; w++) send_word(1);
    repeat (4) @(negedge clk);
    check("t9.ovf", bus_b.o_overflow, 1);
    check("t9.max", bus_b.o_max_addr, 7);
    check_state(1, "t9");

    check("we.single_cycle", n_long_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
